// File: rtl/inst_fetch_resp_if.sv
// Instruction-memory read bus between the fetch responder (master) and the memory (slave).
// A request is held until a one-cycle ack returns the read data.
interface inst_fetch_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/inst_fetch_resp.sv
// Fetch-stage instruction responder: one-entry fetch buffer serving hits at zero latency,
// misses fetched over the req/ack memory bus while a stall is requested.
module inst_fetch_resp #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [DATA_W-1:0] inst,
  output logic              stallreq,
  output logic              inst_addr_err,
  inst_fetch_resp_if.master mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic hit;
  logic mis;
  logic fetch_miss;

  always_comb begin
    mis           = ce & (pc[1:0] != 2'b00);
    hit           = ce & buf_valid_q & (buf_tag_q == pc);
    fetch_miss    = ce & ~mis & ~hit & ~flush;
    inst          = (hit && state_q == IDLE && !flush) ? buf_data_q : '0;
    inst_addr_err = mis;
    stallreq      = ce & ~mis & ~flush & ((state_q != IDLE) | ~hit);
  end

  // A request, once issued, is always held until its ack; a flush only decides whether the data is kept.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    case (state_q)
      IDLE: begin
        if (fetch_miss) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          if (!flush) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = mem_addr_q;
            buf_data_d  = mem.mem_rdata;
          end
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the fetch buffer and the outstanding request.
module tb_inst_fetch_resp;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [AW-1:0] pc;
  logic          flush;
  logic [DW-1:0] inst;
  logic          stallreq;
  logic          inst_addr_err;

  inst_fetch_resp_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  inst_fetch_resp #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ce            (ce),
    .pc            (pc),
    .flush         (flush),
    .inst          (inst),
    .stallreq      (stallreq),
    .inst_addr_err (inst_addr_err),
    .mem           (mem_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the buffer contents plus a list of in-flight fetches (each remembers if its data is still wanted).
  typedef struct {
    logic [31:0] addr;
    bit          keep;
  } fetch_t;

  fetch_t      pending[$];
  bit          m_valid;
  logic [31:0] m_tag;
  logic [31:0] m_data;
  logic [31:0] m_addr;
  int          lat;
  int          stall_seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h3000_0000) return 32'h3401_0001;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pending.delete();
    m_valid = 1'b0;
    m_tag   = '0;
    m_data  = '0;
    m_addr  = '0;
    lat     = 0;
  endtask

  task automatic check_all();
    bit          misal, hit, busy, e_stall;
    logic [31:0] e_inst;
    misal   = ce && (pc[1:0] != 2'b00);
    hit     = ce && m_valid && (m_tag == pc);
    busy    = (pending.size() != 0);
    e_inst  = (hit && !busy && !flush) ? m_data : 32'h0;
    e_stall = ce && !misal && !flush && (busy || !hit);
    check_output("inst", inst, e_inst);
    check_output("stallreq", {31'b0, stallreq}, {31'b0, e_stall});
    check_output("inst_addr_err", {31'b0, inst_addr_err}, {31'b0, misal});
    check_output("mem_req", {31'b0, mem_if.mem_req}, {31'b0, busy});
    check_output("mem_addr", mem_if.mem_addr, m_addr);
    if (stallreq) stall_seen++;
  endtask

  task automatic update_model();
    if (!rst) begin
      model_reset();
    end else if (pending.size() != 0) begin
      if (mem_if.mem_ack) begin
        if (pending[0].keep && !flush) begin
          m_valid = 1'b1;
          m_tag   = pending[0].addr;
          m_data  = mem_if.mem_rdata;
        end
        void'(pending.pop_front());
      end else if (flush) begin
        pending[0].keep = 1'b0;
      end
    end else if (ce && pc[1:0] == 2'b00 && !(m_valid && m_tag == pc) && !flush) begin
      pending.push_back('{addr: pc, keep: 1'b1});
      m_addr = pc;
      lat    = $urandom_range(0, 3);
    end
  endtask

  task automatic apply_stimulus(input bit c, input logic [31:0] p, input bit f, input bit a);
    ce    = c;
    pc    = p;
    flush = f;
    mem_if.mem_ack   = a;
    mem_if.mem_rdata = (a && pending.size() != 0) ? mem_word(pending[0].addr) : $urandom;
    #3;
    check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  logic [31:0] pool[6] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0020,
                           32'h0000_0040, 32'h3000_0000, 32'h0000_1000};

  initial begin
    logic [31:0] cur_pc;
    bit          c, f, a;

    rst   = 1'b0;
    ce    = 1'b0;
    pc    = '0;
    flush = 1'b0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    model_reset();

    // Reset state, including combinational outputs while held in reset.
    apply_stimulus(0, 32'h0, 0, 0);
    apply_stimulus(1, 32'h3000_0000, 0, 0);
    apply_stimulus(1, 32'h3000_0002, 0, 0);
    rst = 1'b1;

    // Cold miss, ack in the second REQ cycle: three stall cycles then a hit.
    stall_seen = 0;
    apply_stimulus(1, 32'h3000_0000, 0, 0);
    apply_stimulus(1, 32'h3000_0000, 0, 0);
    apply_stimulus(1, 32'h3000_0000, 0, 1);
    apply_stimulus(1, 32'h3000_0000, 0, 0);
    check_output("miss_stall_cycles", stall_seen, 32'd3);
    check_output("fill_inst", inst, 32'h3401_0001);

    // Repeat fetches of the buffered pc, with ce dropping in between.
    apply_stimulus(1, 32'h3000_0000, 0, 0);
    apply_stimulus(0, 32'h3000_0000, 0, 0);
    apply_stimulus(1, 32'h3000_0000, 0, 1);

    // Flush while a request is outstanding, then a fresh miss for the new pc.
    apply_stimulus(1, 32'h0000_0040, 0, 0);
    apply_stimulus(1, 32'h0000_0020, 1, 0);
    apply_stimulus(1, 32'h0000_0020, 0, 0);
    apply_stimulus(1, 32'h0000_0020, 1, 0);
    apply_stimulus(1, 32'h0000_0020, 0, 1);
    apply_stimulus(1, 32'h0000_0020, 0, 0);
    apply_stimulus(1, 32'h0000_0020, 0, 0);
    apply_stimulus(1, 32'h0000_0020, 0, 1);
    apply_stimulus(1, 32'h0000_0020, 0, 0);
    apply_stimulus(1, 32'h0000_0040, 0, 0);
    apply_stimulus(1, 32'h0000_0040, 0, 1);
    apply_stimulus(1, 32'h0000_0040, 0, 0);

    // Flush coincident with ack: data dropped, buffered 0x40 still hits.
    apply_stimulus(1, 32'h0000_0100, 0, 0);
    apply_stimulus(1, 32'h0000_0100, 1, 1);
    apply_stimulus(1, 32'h0000_0040, 0, 0);
    apply_stimulus(1, 32'h0000_0040, 0, 0);

    // Misaligned fetch: error flag only, no stall and no request.
    apply_stimulus(1, 32'h3000_0002, 0, 0);
    apply_stimulus(1, 32'h3000_0002, 0, 0);

    // Asynchronous reset mid-request wipes the buffer and the request.
    apply_stimulus(1, 32'h0000_0040, 0, 0);
    apply_stimulus(1, 32'h0000_0300, 0, 0);
    apply_stimulus(1, 32'h0000_0300, 0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    check_output("async_rst_mem_req", {31'b0, mem_if.mem_req}, 32'h0);
    check_all();
    apply_stimulus(1, 32'h0000_0040, 0, 0);
    rst = 1'b1;
    apply_stimulus(1, 32'h0000_0040, 0, 0);
    apply_stimulus(1, 32'h0000_0040, 0, 0);
    apply_stimulus(1, 32'h0000_0040, 0, 1);
    apply_stimulus(1, 32'h0000_0040, 0, 0);

    // Random traffic with variable ack latency, stray acks, flushes and misaligned pcs.
    cur_pc = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) cur_pc = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 15) == 0) cur_pc = pool[$urandom_range(0, 5)] + 32'd2;
      c = ($urandom_range(0, 7) != 0);
      f = ($urandom_range(0, 9) == 0);
      if (pending.size() != 0) begin
        a = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        a = ($urandom_range(0, 7) == 0);
      end
      apply_stimulus(c, cur_pc, f, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
